// File: rtl/parity_accum.sv
// Packet parity accumulator: per-lane XOR parity over a valid/ready word stream, one registered result per packet.
// Optional expected-parity checker (in_exp_parity / out_err) is compiled in when PARITY_CHECK_EN is defined.
module parity_accum #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 1,
    parameter int MAXLEN = 16,
    localparam int CW    = $clog2(MAXLEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             odd_mode,
`ifdef PARITY_CHECK_EN
    input  logic [LANES-1:0] in_exp_parity,
    output logic [LANES-1:0] out_err,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_trunc,
    output logic             busy
);

    localparam int LW = WIDTH / LANES;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [LANES-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             odd_q, odd_d;
    logic             out_valid_q, out_valid_d;
    logic [LANES-1:0] out_parity_q, out_parity_d;
    logic [CW-1:0]    out_count_q, out_count_d;
    logic             out_trunc_q, out_trunc_d;
    logic             busy_q, busy_d;
`ifdef PARITY_CHECK_EN
    logic [LANES-1:0] out_err_q, out_err_d;
`endif

    logic [LANES-1:0] lane_x;
    logic [LANES-1:0] acc_sum;
    logic [CW-1:0]    count_inc;
    logic             accept;
    logic             odd_eff;
    logic             final_word;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_x[gi] = ^in_data[gi*LW +: LW];
        end
    endgenerate

    assign in_ready   = (state_q != S_HOLD);
    assign accept     = in_valid && in_ready;
    assign acc_sum    = acc_q ^ lane_x;
    assign count_inc  = count_q + CW'(1);
    // The parity sense is taken from the first word; later odd_mode changes are ignored.
    assign odd_eff    = (state_q == S_IDLE) ? odd_mode : odd_q;
    assign final_word = in_last || (count_inc == CW'(MAXLEN));

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        odd_d        = odd_q;
        out_valid_d  = out_valid_q;
        out_parity_d = out_parity_q;
        out_count_d  = out_count_q;
        out_trunc_d  = out_trunc_q;
        busy_d       = busy_q;
`ifdef PARITY_CHECK_EN
        out_err_d    = out_err_q;
`endif
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept) begin
                    acc_d   = acc_sum;
                    count_d = count_inc;
                    odd_d   = odd_eff;
                    busy_d  = 1'b1;
                    if (final_word) begin
                        state_d      = S_HOLD;
                        out_valid_d  = 1'b1;
                        out_parity_d = acc_sum ^ {LANES{odd_eff}};
                        out_count_d  = count_inc;
                        out_trunc_d  = !in_last;
`ifdef PARITY_CHECK_EN
                        out_err_d    = acc_sum ^ {LANES{odd_eff}} ^ in_exp_parity;
`endif
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    acc_d       = '0;
                    count_d     = '0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
`ifdef PARITY_CHECK_EN
                    out_err_d   = '0;
`endif
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            count_q      <= '0;
            odd_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_parity_q <= '0;
            out_count_q  <= '0;
            out_trunc_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef PARITY_CHECK_EN
            out_err_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            odd_q        <= odd_d;
            out_valid_q  <= out_valid_d;
            out_parity_q <= out_parity_d;
            out_count_q  <= out_count_d;
            out_trunc_q  <= out_trunc_d;
            busy_q       <= busy_d;
`ifdef PARITY_CHECK_EN
            out_err_q    <= out_err_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign out_parity = out_parity_q;
    assign out_count  = out_count_q;
    assign out_trunc  = out_trunc_q;
    assign busy       = busy_q;
`ifdef PARITY_CHECK_EN
    assign out_err    = out_err_q;
`endif

endmodule

// File: tb/tb_parity_accum.sv
// Bench for parity_accum: a scoreboard for a WIDTH=8/LANES=1 instance plus directed checks on a LANES=2 instance.
module tb_parity_accum;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: WIDTH=8, LANES=1, MAXLEN=16
    logic       in_valid = 1'b0, in_last = 1'b0, odd_mode = 1'b0, out_ready = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_ready, out_valid, out_parity, out_trunc, busy;
    logic [4:0] out_count;
    logic       in_exp_parity = 1'b0;
    logic       out_err;

    parity_accum #(.WIDTH(8), .LANES(1), .MAXLEN(16)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .odd_mode(odd_mode),
`ifdef PARITY_CHECK_EN
        .in_exp_parity(in_exp_parity), .out_err(out_err),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_parity(out_parity),
        .out_count(out_count), .out_trunc(out_trunc), .busy(busy)
    );
`ifndef PARITY_CHECK_EN
    assign out_err = 1'b0;
`endif

    // Instance 1: WIDTH=8, LANES=2, MAXLEN=16
    logic       v1 = 1'b0, last1 = 1'b0, ordy1 = 1'b0;
    logic [7:0] d1 = '0;
    logic       rdy1, oval1, otr1, busy1;
    logic [1:0] opar1;
    logic [4:0] ocnt1;
    logic [1:0] exp1_par = 2'b00;
    logic [1:0] err1;

    parity_accum #(.WIDTH(8), .LANES(2), .MAXLEN(16)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .in_last(last1), .odd_mode(1'b0),
`ifdef PARITY_CHECK_EN
        .in_exp_parity(exp1_par), .out_err(err1),
`endif
        .out_valid(oval1), .out_ready(ordy1), .out_parity(opar1),
        .out_count(ocnt1), .out_trunc(otr1), .busy(busy1)
    );
`ifndef PARITY_CHECK_EN
    assign err1 = 2'b00;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic       par;
        int         cnt;
        logic       trunc;
        logic       err;
    } exp_t;
    exp_t sb[$];

    // Reference model state for instance 0
    logic m_in = 1'b0, m_acc = 1'b0, m_odd = 1'b0;
    int   m_cnt = 0;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_parity", 32'(out_parity), 32'(e.par));
                check("out_count", 32'(out_count), 32'(e.cnt));
                check("out_trunc", 32'(out_trunc), 32'(e.trunc));
`ifdef PARITY_CHECK_EN
                check("out_err", 32'(out_err), 32'(e.err));
`endif
                $display("pkt: parity=%0d count=%0d trunc=%0d err=%0d", out_parity, out_count, out_trunc, out_err);
            end
        end
    end

    task automatic send_word(input logic [7:0] d, input logic last, input logic odd, input logic exp);
        bit ok = 0;
        in_valid = 1'b1; in_data = d; in_last = last; odd_mode = odd; in_exp_parity = exp;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!m_in) begin m_in = 1'b1; m_odd = odd; m_acc = 1'b0; m_cnt = 0; end
        m_acc = m_acc ^ (^d);
        m_cnt++;
        if (last || m_cnt == 16) begin
            exp_t e;
            e.par = m_acc ^ m_odd; e.cnt = m_cnt; e.trunc = !last; e.err = m_acc ^ m_odd ^ exp;
            sb.push_back(e);
            m_in = 1'b0;
            check("valid_next_cycle", 32'(out_valid), 32'd1);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        @(negedge clk); rst = 1'b0;
        idle_cycles(2);

        // Single word, even mode
        send_word(8'hA5, 1'b1, 1'b0, 1'b0);
        idle_cycles(2);

        // Three words; odd_mode change after the first word is ignored
        send_word(8'h01, 1'b0, 1'b1, 1'b0);
        send_word(8'h03, 1'b0, 1'b0, 1'b0);
        send_word(8'h07, 1'b1, 1'b0, 1'b0);
        idle_cycles(2);

        // Truncation at MAXLEN with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_word(8'h01, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        idle_cycles(2);

        // in_last on the MAXLEN-th word: not truncated
        for (int i = 0; i < 15; i++) send_word(8'h10, 1'b0, 1'b1, 1'b0);
        send_word(8'h11, 1'b1, 1'b1, 1'b1);
        idle_cycles(2);

        // Reset mid-packet discards the partial result
        send_word(8'hFF, 1'b0, 1'b0, 1'b0);
        send_word(8'h01, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        m_in = 1'b0;
        @(negedge clk); rst = 1'b0;
        idle_cycles(1);
        send_word(8'h80, 1'b1, 1'b0, 1'b0);
        idle_cycles(2);

        // Reset while holding a result drops out_valid immediately
        out_ready = 1'b0;
        send_word(8'h55, 1'b1, 1'b0, 1'b0);
        void'(sb.pop_back());
        rst = 1'b1; #1;
        check("rsthold_out_valid", 32'(out_valid), 32'd0);
        check("rsthold_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        idle_cycles(1);

`ifdef PARITY_CHECK_EN
        send_word(8'h03, 1'b1, 1'b0, 1'b1);
        idle_cycles(2);
        send_word(8'h03, 1'b1, 1'b0, 1'b0);
        idle_cycles(2);
`endif

        // Two-lane instance with a stalled consumer
        begin
            logic [1:0] exp_par;
            exp_par = {^d1[7:4], ^d1[3:0]};
            v1 = 1'b1; d1 = 8'h1F; last1 = 1'b0;
            exp_par = {1'b1, 1'b0};
            @(posedge clk); #1;
            d1 = 8'hF0; last1 = 1'b1;
            exp_par = exp_par ^ {^d1[7:4], ^d1[3:0]};
            @(posedge clk); #1;
            v1 = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("l2_out_valid", 32'(oval1), 32'd1);
                check("l2_out_parity", 32'(opar1), 32'(exp_par));
                check("l2_out_count", 32'(ocnt1), 32'd2);
                check("l2_in_ready", 32'(rdy1), 32'd0);
            end
            $display("lane2 pkt: parity=%0b count=%0d", opar1, ocnt1);
            ordy1 = 1'b1;
            @(posedge clk); #1;
            check("l2_release_valid", 32'(oval1), 32'd0);
            check("l2_release_busy", 32'(busy1), 32'd0);
        end

        idle_cycles(3);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
